// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered, parametrised EX-stage ALU with an iterative multiplier.
//
// Executes AND/OR/ADD/XOR/SLL/SRL/SUB/SRA/SLT/SLTU in one cycle and an unsigned
// WIDTH x WIDTH -> 2*WIDTH multiply in WIDTH shift-add steps. A valid/ready
// handshake lets the EX stage stall while the multiplier is busy.
//
// Parameters
//   WIDTH        operand/result width (power of two, >= 4)
//   SHW          shift-amount width, derived from WIDTH (do not override)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     operation request
//   in_ready     block can accept an operation this cycle (IDLE and not in reset)
//   data1        operand A
//   data2        operand B; data2[SHW-1:0] is the shift amount
//   ALU_control  4-bit opcode
//   out_valid    one-cycle pulse: result registers were just updated
//   ALU_result   result (low product word for MUL)
//   result_hi    high product word for MUL, 0 for every other op
//   zero         ALU_result == 0, updated with out_valid
//   overflow     signed overflow for ADD/SUB, 0 otherwise, updated with out_valid
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1010
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;          // multiply step index, 0..WIDTH-1
  logic [WIDTH-1:0] mcand_q, mcand_d;      // latched multiplicand (data1)
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;  // partial-product accumulator
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;  // multiplier, shifted out as product low bits
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  op_e              op;
  logic             accept;
  logic             mul_last;

  assign op       = op_e'(ALU_control);
  assign in_ready = !reset && (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign mul_last = (cnt_q == SHW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign sum   = data1 + data2;
  assign diff  = data1 - data2;
  assign shamt = data2[SHW-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path through the block leaves it unassigned (which would infer a latch).
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_res = data1 & data2;
      OP_OR:   alu_res = data1 | data2;
      OP_XOR:  alu_res = data1 ^ data2;
      OP_ADD: begin
        alu_res = sum;
        // Same-sign operands producing a result of the other sign.
        alu_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                  (sum[WIDTH-1]   != data1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        // Opposite-sign operands with the result sign flipped away from A.
        alu_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                  (diff[WIDTH-1]  != data1[WIDTH-1]);
      end
      OP_SLL:  alu_res = data1 << shamt;
      OP_SRL:  alu_res = data1 >> shamt;
      OP_SRA:  alu_res = $signed(data1) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      default: begin
        // MUL is handled by the FSM; unused codes give 0.
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply step: conditionally add the multiplicand into the high half, then
  // shift {carry, hi, lo} right by one. After WIDTH steps {hi, lo} is A*B.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] mul_shift;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign mul_sum = {1'b0, prod_hi_q} + {1'b0, mcand_q};

  always_comb begin
    mul_shift = {1'b0, prod_hi_q, prod_lo_q};
    if (prod_lo_q[0]) begin
      mul_shift = {mul_sum, prod_lo_q};
    end
  end

  assign step_hi = mul_shift[2*WIDTH:WIDTH+1];
  assign step_lo = mul_shift[WIDTH:1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    res_d     = res_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d   = data1;
            prod_hi_d = '0;
            prod_lo_d = data2;
            cnt_d     = '0;
            state_d   = S_MUL;
          end else begin
            res_d   = alu_res;
            hi_d    = '0;
            zero_d  = (alu_res == '0);
            ovf_d   = alu_ovf;
            valid_d = 1'b1;
          end
        end
      end

      S_MUL: begin
        prod_hi_d = step_hi;
        prod_lo_d = step_lo;
        if (mul_last) begin
          // Counter stays at WIDTH-1; it is cleared again on the next accept.
          res_d   = step_lo;
          hi_d    = step_hi;
          zero_d  = (step_lo == '0);
          ovf_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + SHW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      // NOTE: the operand and accumulator registers are reset too, so an
      // aborted multiply never leaves stale or X state behind.
      mcand_q   <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      res_q     <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      res_q     <= res_d;
      hi_q      <= hi_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign ALU_result = res_q;
  assign result_hi  = hi_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the pipeline's combinational 8-bit ALU. It executes the original AND/OR/ADD/SUB codes plus XOR, shifts, set-less-than and an iterative unsigned multiply. Operand width is set by `WIDTH`. Results are registered, and a valid/ready handshake lets the EX stage stall on multi-cycle ops. The block sits in the EX stage; its registered result feeds EX/MEM directly.

## Interface
- `WIDTH`, default 8: operand/result width. Must be a power of two, ≥4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept an operation this cycle.
- `data1`  in  WIDTH  operand A.
- `data2`  in  WIDTH  operand B; `data2[SHW-1:0]` is the shift amount.
- `ALU_control`  in  4  opcode.
- `out_valid`  out  1  one-cycle pulse: result registers updated.
- `ALU_result`  out  WIDTH  result; low word for MUL.
- `result_hi`  out  WIDTH  MUL high word; 0 for all other ops.
- `zero`  out  1  `ALU_result == 0`.
- `overflow`  out  1  signed overflow for ADD/SUB; 0 otherwise.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU, 1010 MUL (unsigned, 2·WIDTH product).
  - Any other code: result 0, `zero`=1, `overflow`=0.
- Accept: on a rising edge where `in_valid && in_ready`.
- `in_ready` = `!reset && state==IDLE`. It is combinational from state only, not from `in_valid`.
- States:
  - IDLE: a single-cycle op accepted here registers its result and stays in IDLE. MUL accepted here latches the operands, clears the accumulator and counter, and moves to MUL.
  - MUL: one shift-add step per edge, `WIDTH` steps total. On the final step it writes `{result_hi, ALU_result}`, pulses `out_valid` and returns to IDLE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Overflow is signed: ADD when both operand signs are equal and the result sign differs; SUB when the operand signs differ and the result sign differs from `data1`.
  - SLT/SLTU produce 1 or 0 in bit 0, zero-extended.
  - Shift amounts use `data2[SHW-1:0]` only; upper bits are ignored. SRA replicates the MSB.
  - MUL: `ALU_result`/`result_hi` are the low/high words of the product; `overflow`=0.
- Operand changes while in MUL are ignored; the operands were latched at accept.
- `zero` and `overflow` update only together with `out_valid`.
- All result outputs hold their last value between pulses.
- `in_valid` while `in_ready`=0 is ignored. It is not queued; the requester must hold it.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state=IDLE; `out_valid`, `ALU_result`, `result_hi`, `overflow` = 0; `zero`=0; counter=0.
  - `in_ready`=0 while `reset` is high and 1 in the first cycle after release.
- Single-cycle op accepted at edge k: `out_valid`=1 for the cycle after edge k only. Throughput is one op per cycle with no bubbles.
- MUL accepted at edge k:
  - `in_ready`=0 from after edge k through edge k+WIDTH.
  - Result and `out_valid`=1 appear after edge k+WIDTH.
  - `in_ready`=1 in that same cycle, so the next accept is at edge k+WIDTH+1.
  - Latency is WIDTH cycles.
- `out_valid` never asserts in consecutive cycles for MUL; it may for back-to-back single-cycle ops.
- Reset during MUL: the operation is aborted, no `out_valid` is produced, and outputs go to reset values immediately.
- Counter wrap: the step counter runs 0..WIDTH-1 and is cleared at accept; it never wraps mid-operation.

## Test plan
- ADD with `WIDTH`=8: `data1`=0x7F, `data2`=0x01, accept at edge k -> after edge k `ALU_result`=0x80, `overflow`=1, `zero`=0, `out_valid` high exactly one cycle.
- Back-to-back on consecutive edges: SUB 0x55-0x55, then SRA 0x80 by `data2`=0x0B (amount 3), then SLT 0xFF,0x01, then SLTU 0xFF,0x01 -> results 0x00 (`zero`=1), 0xF0, 0x01, 0x00 on four consecutive cycles; `in_ready` stays 1.
- MUL 0xFF×0xFF, with `data1`/`data2` randomised during busy -> `in_ready` low 8 cycles; `out_valid` after edge k+8; `result_hi`=0xFE, `ALU_result`=0x01; a second `in_valid` held during busy is accepted at edge k+9.
- Reset pulse asserted mid-MUL (after edge k+4) -> outputs 0 asynchronously, no `out_valid` ever for that op, `in_ready`=1 the cycle after release; a following ADD 3+4 returns 7 with latency 1.
- Illegal opcode 1111 and `WIDTH`=16 regression: SLL 0x0001 by `data2`=0x0013 (amount 3) -> 0x0008; MUL 0xFFFF×0x0002 -> `result_hi`=0x0001, `ALU_result`=0xFFFE after 16 cycles; opcode 1111 -> result 0, `zero`=1, `overflow`=0, latency 1.
